// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its branch-condition helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simp_seq_pkg;

  typedef enum logic [1:0] {
    HALT   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    TARGET = 2'd3
  } state_t;

  // Bit positions inside the {C,O,P,N,Z} flag vector returned by the ALU
  localparam int FLAG_C = 4;
  localparam int FLAG_O = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [7:0] HALT_OP   = 8'hFF;
  localparam logic [2:0] JMP_CLASS = 3'b111;

  // Condition selector carried in opcode bits [4:2]; 6 and 7 mean "never"
  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_Z      = 3'd1;
  localparam logic [2:0] CC_N      = 3'd2;
  localparam logic [2:0] CC_P      = 3'd3;
  localparam logic [2:0] CC_O      = 3'd4;
  localparam logic [2:0] CC_C      = 3'd5;

  // HALT shares the jump class prefix, so it has to be excluded explicitly
  function automatic logic is_jmp(input logic [7:0] op);
    return (op[7:5] == JMP_CLASS) && (op != HALT_OP);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory read port: registered req/addr out, data/ack back.
// Latency: ack may come in the first req cycle (zero wait) or any number of cycles later.
// Backpressure: memory stalls by withholding ack; req/addr hold until the ack cycle.
// Ports: pmem_req, pmem_addr (sequencer -> memory); pmem_data, pmem_ack (memory -> sequencer).
interface fetch_sequencer_if;
  logic       pmem_req;
  logic [7:0] pmem_addr;
  logic [7:0] pmem_data;
  logic       pmem_ack;

  modport master (output pmem_req, output pmem_addr, input pmem_data, input pmem_ack);
  modport slave  (input pmem_req, input pmem_addr, output pmem_data, output pmem_ack);
endinterface

// File: rtl/fetch_sequencer_branch_cond.sv
// Decides whether a conditional jump is taken from opcode bits [4:1] and the ALU flags.
// Latency: combinational.
// Backpressure: none.
// Ports: i_cc = IR[4:1] (selector in [3:1], invert in [0]); i_flags = {C,O,P,N,Z}; o_take.
module branch_cond
  import simp_seq_pkg::*;
(
  input  logic [3:0] i_cc,
  input  logic [4:0] i_flags,
  output logic       o_take
);

  logic w_raw;

  always_comb begin
    w_raw = 1'b0;
    case (i_cc[3:1])
      CC_ALWAYS: w_raw = 1'b1;
      CC_Z:      w_raw = i_flags[FLAG_Z];
      CC_N:      w_raw = i_flags[FLAG_N];
      CC_P:      w_raw = i_flags[FLAG_P];
      CC_O:      w_raw = i_flags[FLAG_O];
      CC_C:      w_raw = i_flags[FLAG_C];
      default:   w_raw = 1'b0;
    endcase
  end

  // Inverting "never" yields an unconditional jump as well
  assign o_take = w_raw ^ i_cc[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, fetches bytes, issues ALU ops, runs jumps/HALT.
// Latency: ALU op = FETCH+EXEC (2 cycles at zero wait), jump = FETCH+TARGET, each wait adds one.
// Backpressure: stalls in FETCH/TARGET with req/addr held until pmem_ack; ack without req is ignored.
// Ports: ck, rst_n (async low), run, flags {C,O,P,N,Z}; pmem (master modport);
//        instr (one-cycle ALU op, NOP otherwise), pc, halted.
module fetch_sequencer
  import simp_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] NOP_INSTR = 8'h00
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [4:0]               flags,
  fetch_sequencer_if.master        pmem,
  output logic [7:0]               instr,
  output logic [7:0]               pc,
  output logic                     halted
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic [7:0] r_addr;
  logic [7:0] r_instr, w_instr_nxt;
  logic       r_req, w_req_nxt;
  logic       r_halted;
  logic       w_ack;
  logic       w_take;

  // Only an ack that lands on our own outstanding request is consumed
  assign w_ack = pmem.pmem_ack & r_req;

  branch_cond u_branch_cond (
    .i_cc    (r_ir[4:1]),
    .i_flags (flags),
    .o_take  (w_take)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      HALT: begin
        if (run) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (w_ack) begin
          w_ir_nxt = pmem.pmem_data;
          w_pc_nxt = r_pc + 8'd1;
          if (pmem.pmem_data == HALT_OP)   w_state_nxt = HALT;
          else if (is_jmp(pmem.pmem_data)) w_state_nxt = TARGET;
          else                             w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = FETCH;
      end
      TARGET: begin
        if (w_ack) begin
          w_pc_nxt    = w_take ? pmem.pmem_data : r_pc + 8'd1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = HALT;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  assign w_req_nxt   = (w_state_nxt == FETCH) || (w_state_nxt == TARGET);
  assign w_instr_nxt = (w_state_nxt == EXEC) ? w_ir_nxt : NOP_INSTR;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HALT;
      r_pc     <= RESET_PC;
      r_ir     <= 8'h00;
      r_addr   <= RESET_PC;
      r_req    <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_halted <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      // Read address always tracks the PC; it only matters while req is high
      r_addr   <= w_pc_nxt;
      r_req    <= w_req_nxt;
      r_instr  <= w_instr_nxt;
      r_halted <= (w_state_nxt == HALT);
    end
  end

  assign pmem.pmem_req  = r_req;
  assign pmem.pmem_addr = r_addr;
  assign instr          = r_instr;
  assign pc             = r_pc;
  assign halted         = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder with configurable waits/stray acks, scoreboard of
// issued ALU ops from a program-walking reference model, handshake-hold monitor, directed cases.
// Ends with one summary line.
module tb_fetch_sequencer;

  localparam logic [7:0] NOP = 8'h00;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [4:0] flags = 5'd0;
  logic [7:0] instr;
  logic [7:0] pc;
  logic       halted;

  fetch_sequencer_if pmem_if ();

  fetch_sequencer #(.RESET_PC(8'h00), .NOP_INSTR(8'h00)) dut (
    .ck     (ck),
    .rst_n  (rst_n),
    .run    (run),
    .flags  (flags),
    .pmem   (pmem_if.master),
    .instr  (instr),
    .pc     (pc),
    .halted (halted)
  );

  always #5 ck = ~ck;

  logic [7:0] rom [256];
  int         wait_cfg = 0;
  bit         stray_en = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_pc = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program memory: answers req after wait_cfg idle cycles; may ack spuriously while req is low
  initial begin
    int cnt;
    cnt = 0;
    pmem_if.pmem_ack  = 1'b0;
    pmem_if.pmem_data = 8'h00;
    forever begin
      @(negedge ck);
      if (rst_n && pmem_if.pmem_req) begin
        if (cnt >= wait_cfg) begin
          pmem_if.pmem_ack  = 1'b1;
          pmem_if.pmem_data = rom[pmem_if.pmem_addr];
          cnt = 0;
        end else begin
          pmem_if.pmem_ack  = 1'b0;
          pmem_if.pmem_data = 8'($urandom);
          cnt++;
        end
      end else begin
        cnt = 0;
        if (stray_en && ($urandom_range(0, 1) == 1)) begin
          pmem_if.pmem_ack  = 1'b1;
          pmem_if.pmem_data = 8'($urandom);
        end else begin
          pmem_if.pmem_ack  = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard on issued instructions plus request-hold protocol check
  initial begin
    logic       prev_req;
    logic [7:0] prev_addr;
    logic       prev_nn;
    logic [7:0] e;
    prev_req = 1'b0; prev_addr = 8'h00; prev_nn = 1'b0;
    forever begin
      @(posedge ck);
      #1;
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_nn  = 1'b0;
      end else begin
        // Ack still shows the value consumed on this edge
        if (prev_req && !pmem_if.pmem_ack) begin
          check("req_hold", 32'(pmem_if.pmem_req), 32'd1);
          check("addr_hold", 32'(pmem_if.pmem_addr), 32'(prev_addr));
        end
        if (instr !== NOP) begin
          check("no_back_to_back", 32'(prev_nn), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL instr_unexpected: got %0h expected none (t=%0t)", instr, $time);
          end else begin
            e = exp_q.pop_front();
            check("instr", 32'(instr), 32'(e));
          end
          prev_nn = 1'b1;
        end else begin
          prev_nn = 1'b0;
        end
        prev_req  = pmem_if.pmem_req;
        prev_addr = pmem_if.pmem_addr;
      end
    end
  end

  // Reference model: walk the program the way the encoding defines it
  function automatic logic cond_ok(input logic [7:0] op, input logic [4:0] f);
    logic t;
    case (op[4:2])
      3'd0:    t = 1'b1;
      3'd1:    t = f[0];
      3'd2:    t = f[1];
      3'd3:    t = f[2];
      3'd4:    t = f[3];
      3'd5:    t = f[4];
      default: t = 1'b0;
    endcase
    return t ^ op[1];
  endfunction

  task automatic model_run();
    logic [7:0] p;
    logic [7:0] op;
    p = m_pc;
    for (int s = 0; s < 600; s++) begin
      op = rom[p];
      p  = p + 8'd1;
      if (op == 8'hFF) break;
      if (op[7:5] == 3'b111) begin
        if (cond_ok(op, flags)) p = rom[p];
        else                    p = p + 8'd1;
      end else begin
        exp_q.push_back(op);
      end
    end
    m_pc = p;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst_n = 1'b0;
    run = 1'b0;
    stray_en = 1'b0;
    exp_q.delete();
    m_pc = 8'h00;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge after the first FETCH cycle has begun
  task automatic start();
    model_run();
    @(negedge ck);
    run = 1'b1;
    @(negedge ck);
    run = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int k;
    k = 0;
    while (!halted && k < 3000) begin
      @(negedge ck);
      k++;
    end
    if (!halted) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: halted=0 expected 1", tag);
    end
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    repeat (2) @(negedge ck);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic jump_case(input logic [7:0] op, input logic [4:0] f, input logic [7:0] exp_pc,
                           input string tag);
    do_reset();
    fill_rom();
    rom[0] = op;
    rom[1] = 8'h40;
    flags = f;
    start();
    @(negedge ck);
    check({tag, "_tgt_addr"}, 32'(pmem_if.pmem_addr), 32'h01);
    @(negedge ck);
    check({tag, "_jmp_pc"}, 32'(pc), 32'(exp_pc));
    finish_run(tag);
  endtask

  // Jump always to FE where a HALT leaves pc at FF
  task automatic go_to_ff();
    do_reset();
    fill_rom();
    rom[8'h00] = 8'hE0;
    rom[8'h01] = 8'hFE;
    start();
    finish_run("to_ff");
  endtask

  initial begin
    int L;
    int a;
    logic [7:0] op;
    fill_rom();
    do_reset();

    // Reset state and first fetch
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_req", 32'(pmem_if.pmem_req), 32'd0);
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_addr", 32'(pmem_if.pmem_addr), 32'h00);
    rom[0] = 8'h12;
    rom[1] = 8'hFF;
    start();
    check("run_req", 32'(pmem_if.pmem_req), 32'd1);
    check("run_addr", 32'(pmem_if.pmem_addr), 32'h00);
    @(negedge ck);
    check("alu_instr", 32'(instr), 32'h12);
    @(negedge ck);
    check("alu_nop_after", 32'(instr), 32'h00);
    check("alu_next_addr", 32'(pmem_if.pmem_addr), 32'h01);
    @(negedge ck);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'h02);
    finish_run("alu");

    // Conditional jumps, taken and not taken
    jump_case(8'hE4, 5'b00001, 8'h40, "jz_set");
    jump_case(8'hE4, 5'b00000, 8'h02, "jz_clr");
    jump_case(8'hE6, 5'b00001, 8'h02, "jnz_set");
    jump_case(8'hE6, 5'b00000, 8'h40, "jnz_clr");

    // Three wait cycles: req/addr held for four cycles, then stray acks while halted
    do_reset();
    fill_rom();
    rom[0] = 8'h12;
    rom[1] = 8'hFF;
    wait_cfg = 3;
    start();
    for (int i = 0; i < 4; i++) begin
      check("wait_req", 32'(pmem_if.pmem_req), 32'd1);
      check("wait_addr", 32'(pmem_if.pmem_addr), 32'h00);
      @(negedge ck);
    end
    check("wait_req_drop", 32'(pmem_if.pmem_req), 32'd0);
    check("wait_instr", 32'(instr), 32'h12);
    finish_run("wait");
    stray_en = 1'b1;
    repeat (10) @(negedge ck);
    stray_en = 1'b0;
    check("stray_pc", 32'(pc), 32'(m_pc));
    check("stray_halted", 32'(halted), 32'd1);
    wait_cfg = 0;

    // PC wrap: ALU op at FF, then a jump at FF whose target byte sits at 00
    go_to_ff();
    rom[8'hFF] = 8'h33;
    rom[8'h00] = 8'hFF;
    start();
    @(negedge ck);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_instr", 32'(instr), 32'h33);
    finish_run("wrap_alu");
    go_to_ff();
    rom[8'hFF] = 8'hE0;
    rom[8'h00] = 8'h50;
    start();
    @(negedge ck);
    check("wrap_tgt_req", 32'(pmem_if.pmem_req), 32'd1);
    check("wrap_tgt_addr", 32'(pmem_if.pmem_addr), 32'h00);
    @(negedge ck);
    check("wrap_jmp_pc", 32'(pc), 32'h50);
    finish_run("wrap_jmp");

    // Reset while TARGET waits for ack, then late acks must be ignored
    do_reset();
    fill_rom();
    rom[0] = 8'hE0;
    rom[1] = 8'h40;
    wait_cfg = 3;
    start();
    repeat (4) @(negedge ck);
    check("tgt_wait_req", 32'(pmem_if.pmem_req), 32'd1);
    check("tgt_wait_addr", 32'(pmem_if.pmem_addr), 32'h01);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(pmem_if.pmem_req), 32'd0);
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_halted", 32'(halted), 32'd1);
    m_pc = 8'h00;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    wait_cfg = 0;
    stray_en = 1'b1;
    repeat (8) @(negedge ck);
    stray_en = 1'b0;
    check("late_ack_pc", 32'(pc), 32'h00);
    check("late_ack_halted", 32'(halted), 32'd1);
    check("late_ack_req", 32'(pmem_if.pmem_req), 32'd0);

    // Random forward-only programs ending in HALT
    for (int it = 0; it < 40; it++) begin
      do_reset();
      fill_rom();
      L = $urandom_range(4, 40);
      a = 0;
      while (a < L - 1) begin
        if ($urandom_range(0, 9) < 3 && a + 2 <= L - 1) begin
          op = {3'b111, 5'($urandom)};
          if (op == 8'hFF) op = 8'hFE;
          rom[a]     = op;
          rom[a + 1] = 8'($urandom_range(a + 2, L - 1));
          a += 2;
        end else begin
          rom[a] = 8'($urandom_range(1, 8'hDF));
          a += 1;
        end
      end
      rom[L - 1] = 8'hFF;
      flags = 5'($urandom);
      wait_cfg = $urandom_range(0, 3);
      stray_en = 1'($urandom_range(0, 1));
      start();
      finish_run("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
